alu_seq: RTL and testbench

- Parametrised, handshaked successor to the team's single-cycle 2-bit-opcode ALU.
- Adds subtract/compare with borrow, logical shifts and an unsigned multiply.
- Shifts and multiply are computed iteratively over several cycles; all other ops complete in one cycle.
- Result and flags are registered and stay stable until the consumer accepts them. Sits between decode/register-read and writeback in the processor datapath.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 154 +++++++++++++++
 tb/tb_alu_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the issuing stage and alu_seq.
// The master drives the operation and out_ready; the slave returns the result.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [1:0]       flags;

  modport master (
    output in_valid, alu_op, data_a, data_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, alu_op, data_a, data_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle arithmetic/logic ops, iterative shifts and shift-add multiply.
// Result and flags are registered and held until out_ready.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int CW   = SH_W + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_EQ   = 3'b010;
  localparam logic [2:0] OP_ADDM = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("alu_seq: WIDTH must be a power of two and at least 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_d;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] lo, hi, mcand;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       flags_q;

  logic             accept, multi;
  logic [SH_W-1:0]  amt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_1c;
  logic [1:0]       flg_1c;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign amt    = bus.data_b[SH_W-1:0];
  assign multi  = (bus.alu_op == OP_MUL) ||
                  (((bus.alu_op == OP_SHL) || (bus.alu_op == OP_SHR)) && (amt != '0));

  assign sum  = {1'b0, bus.data_a} + {1'b0, bus.data_b};
  assign diff = {1'b0, bus.data_a} - {1'b0, bus.data_b};

  // Single-cycle results; shifts land here only for a zero shift amount.
  always_comb begin
    res_1c = bus.data_a;
    flg_1c = flags_q;
    case (bus.alu_op)
      OP_ADD: begin
        res_1c = sum[WIDTH-1:0];
        flg_1c = {sum[WIDTH], sum[WIDTH-1:0] == '0};
      end
      OP_NAND: res_1c = ~(bus.data_a & bus.data_b);
      OP_EQ: begin
        res_1c = diff[WIDTH-1:0];
        flg_1c = {diff[WIDTH], bus.data_a == bus.data_b};
      end
      OP_ADDM: begin
        res_1c    = sum[WIDTH-1:0];
        flg_1c[0] = (sum[WIDTH-1:0] == '0);
      end
      OP_SHL, OP_SHR: flg_1c = {1'b0, bus.data_a == '0};
      default: ;
    endcase
  end

  // One iteration step. For MUL, {hi,lo} is the partial product with the
  // multiplier consumed from lo's LSB as the product shifts in from the top.
  logic [WIDTH:0]   madd;
  logic [WIDTH-1:0] lo_nx, hi_nx;
  logic             sh_out, fin_c;

  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

  always_comb begin
    lo_nx  = lo;
    hi_nx  = hi;
    sh_out = 1'b0;
    case (op_q)
      OP_SHL: begin
        lo_nx  = {lo[WIDTH-2:0], 1'b0};
        sh_out = lo[WIDTH-1];
      end
      OP_SHR: begin
        lo_nx  = {1'b0, lo[WIDTH-1:1]};
        sh_out = lo[0];
      end
      OP_MUL: begin
        hi_nx = madd[WIDTH:1];
        lo_nx = {madd[0], lo[WIDTH-1:1]};
      end
      default: ;
    endcase
    fin_c = (op_q == OP_MUL) ? (hi_nx != '0) : sh_out;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = multi ? BUSY : DONE;
      BUSY: if (cnt == CW'(1)) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      cnt      <= '0;
      lo       <= '0;
      hi       <= '0;
      mcand    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.alu_op;
          lo    <= (bus.alu_op == OP_MUL) ? bus.data_b : bus.data_a;
          hi    <= '0;
          mcand <= bus.data_a;
          cnt   <= (bus.alu_op == OP_MUL) ? CW'(WIDTH) : {1'b0, amt};
          if (!multi) begin
            result_q <= res_1c;
            flags_q  <= flg_1c;
          end
        end
        BUSY: begin
          lo  <= lo_nx;
          hi  <= hi_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_q <= lo_nx;
            flags_q  <= {fin_c, lo_nx == '0};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, random ops against an arithmetic
// model, plus back-pressure, busy-ignore and mid-multiply reset sequences.
module tb_alu_seq;
  localparam int W = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_EQ   = 3'b010;
  localparam logic [2:0] OP_ADDM = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] mflags = 2'b00;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    logic [1:0]   flg;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference computed from plain integer arithmetic on the op definitions.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] fin, output logic [W-1:0] r,
                                output logic [1:0] f, output int lat);
    longint unsigned s, p;
    int n;
    f   = fin;
    lat = 1;
    r   = a;
    n   = int'(b) % W;
    case (op)
      OP_ADD:  begin s = longint'(a) + longint'(b); r = W'(s); f = {s > 64'hFFFF, r == 0}; end
      OP_NAND: r = ~(a & b);
      OP_EQ:   begin r = W'(a - b); f = {a < b, a == b}; end
      OP_ADDM: begin s = longint'(a) + longint'(b); r = W'(s); f[0] = (r == 0); end
      OP_SHL: begin
        if (n == 0) f = {1'b0, a == 0};
        else begin
          s = longint'(a) << n; r = W'(s); f = {((s >> W) & 1) == 1, r == 0}; lat = n + 1;
        end
      end
      OP_SHR: begin
        if (n == 0) f = {1'b0, a == 0};
        else begin
          r = a >> n; f = {((a >> (n - 1)) & 1) == 1, r == 0}; lat = n + 1;
        end
      end
      OP_MUL: begin
        p = longint'(a) * longint'(b); r = W'(p); f = {(p >> W) != 0, r == 0}; lat = W + 1;
      end
      default: ;
    endcase
  endfunction

  // Issue one op from IDLE and wait for out_valid; lat counts edges from accept.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output logic [W-1:0] r, output logic [1:0] f,
                        output int lat);
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.data_a   = a;
    bus.data_b   = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_a   = W'($urandom);
    bus.data_b   = W'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && poke) begin
        chk("in_ready_busy", bus.in_ready, 0);
        bus.in_valid = lat[0];
        bus.alu_op   = OP_ADD;
      end
    end while (!bus.out_valid && lat < 100);
    bus.in_valid = 1'b0;
    chk("out_valid", bus.out_valid, 1);
    r = bus.result;
    f = bus.flags;
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_retire", bus.in_ready, 1);
    chk("out_valid_after_retire", bus.out_valid, 0);
  endtask

  task automatic run_checked(input string name, input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit poke);
    logic [W-1:0] er, r;
    logic [1:0]   ef, f;
    int           el, lat;
    model(op, a, b, mflags, er, ef, el);
    run_op(op, a, b, poke, r, f, lat);
    chk({name, "_res"}, r, er);
    chk({name, "_flags"}, f, ef);
    chk({name, "_lat"}, lat, el);
    mflags = ef;
    retire();
  endtask

  vec_t tbl[15];

  initial begin
    logic [W-1:0] r;
    logic [1:0]   f;
    int           lat, seen;

    tbl[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 2'b11, 1};
    tbl[1]  = '{OP_NAND, 16'hFFFF, 16'hFFFF, 16'h0000, 2'b11, 1};
    tbl[2]  = '{OP_EQ,   16'h0003, 16'h0003, 16'h0000, 2'b01, 1};
    tbl[3]  = '{OP_EQ,   16'h0002, 16'h0005, 16'hFFFD, 2'b10, 1};
    tbl[4]  = '{OP_SHL,  16'h8001, 16'h0001, 16'h0002, 2'b10, 2};
    tbl[5]  = '{OP_SHR,  16'h00F0, 16'h0004, 16'h000F, 2'b00, 5};
    tbl[6]  = '{OP_SHL,  16'h1234, 16'h0000, 16'h1234, 2'b00, 1};
    tbl[7]  = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 2'b11, 17};
    tbl[8]  = '{OP_MUL,  16'h0007, 16'h0006, 16'h002A, 2'b00, 17};
    tbl[9]  = '{OP_ADDM, 16'hFFFF, 16'h0001, 16'h0000, 2'b01, 1};
    tbl[10] = '{OP_NOP,  16'h0055, 16'h1111, 16'h0055, 2'b01, 1};
    tbl[11] = '{OP_ADD,  16'h0001, 16'h0002, 16'h0003, 2'b00, 1};
    tbl[12] = '{OP_SHR,  16'h8000, 16'h000F, 16'h0001, 2'b00, 16};
    tbl[13] = '{OP_SHL,  16'h0001, 16'h000F, 16'h8000, 2'b00, 16};
    tbl[14] = '{OP_NAND, 16'h0F0F, 16'h00FF, 16'hFFF0, 2'b00, 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = OP_NOP;
    bus.data_a    = '0;
    bus.data_b    = '0;

    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", bus.flags, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, r, f, lat);
      chk($sformatf("vec%0d_res", i), r, tbl[i].res);
      chk($sformatf("vec%0d_flags", i), f, tbl[i].flg);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      mflags = tbl[i].flg;
      retire();
    end

    // Requests offered while multiplying must be ignored.
    run_checked("mul_poke", OP_MUL, 16'h00FF, 16'h0101, 1'b1);
    chk("no_stray_valid", bus.out_valid, 0);

    // Back-pressure: result held across 10 stalled cycles.
    run_op(OP_ADD, 16'h1234, 16'h1111, 1'b0, r, f, lat);
    chk("bp_res", r, 16'h2345);
    chk("bp_flags", f, 2'b00);
    mflags = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_res", bus.result, 16'h2345);
      chk("bp_hold_flags", bus.flags, 2'b00);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_ready", bus.in_ready, 0);
    end
    retire();

    for (int i = 0; i < 80; i++) begin
      run_checked("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0);
    end

    // Reset during the 8th multiply iteration aborts the op.
    run_checked("pre_rst_add", OP_ADD, 16'hFFFF, 16'h0002, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.alu_op   = OP_MUL;
    bus.data_a   = 16'h0123;
    bus.data_b   = 16'h0456;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_flags", bus.flags, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mflags = 2'b00;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("aborted_no_valid", seen, 0);
    run_checked("post_rst_add", OP_ADD, 16'h0002, 16'h0003, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
